// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: holds the PC, fetches over imem req/ack, and advances the PC when an instruction retires.
// Define FETCH_TIMEOUT_EN to build the REQ watchdog that pulses fetch_err and re-issues the request.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic            instr_valid,
  input  logic            ex_done,
  input  logic            brnch,
  input  logic            zero,
  input  logic [XLEN-1:0] br_offset,
  output logic [XLEN-1:0] pc,
  output logic [15:0]     instr_count,
  output logic            fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_EXEC} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_d, imem_addr_d, pc_sum_c, next_pc_c;
  logic [31:0]     instr_d;
  logic [15:0]     instr_count_d;
  logic            imem_req_d, instr_valid_d;
  logic            timeout_c;

  if (TIMEOUT == 0) begin : g_timeout_check
    $error("instr_fetch_unit: TIMEOUT must be at least 1");
  end

  // Branch target or fall-through, word aligned, wrapping modulo 2^XLEN.
  assign pc_sum_c  = (brnch & zero) ? pc + br_offset : pc + XLEN'(4);
  assign next_pc_c = {pc_sum_c[XLEN-1:2], 2'b00};
  assign opcode    = instr[6:0];

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] to_cnt_q;

  assign timeout_c = (state_q == S_REQ) && imem_req && !imem_ack &&
                     (to_cnt_q == CNT_W'(TIMEOUT - 1));

  // Counts live REQ cycles; idle outside REQ, in the drop cycle and on ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q  <= '0;
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= timeout_c;
      if ((state_q != S_REQ) || !imem_req || imem_ack || timeout_c) to_cnt_q <= '0;
      else                                                           to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end
`else
  assign timeout_c = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      instr       <= instr_d;
      imem_req    <= imem_req_d;
      imem_addr   <= imem_addr_d;
      instr_valid <= instr_valid_d;
      instr_count <= instr_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc;
    instr_d       = instr;
    imem_req_d    = imem_req;
    imem_addr_d   = imem_addr;
    instr_valid_d = instr_valid;
    instr_count_d = instr_count;
    case (state_q)
      S_IDLE: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
        if (run) begin
          state_d     = S_REQ;
          imem_req_d  = 1'b1;
          imem_addr_d = pc;
        end
      end
      S_REQ: begin
        if (timeout_c) begin
          imem_req_d = 1'b0;
        end else if (!imem_req) begin
          // Drop cycle after a timeout: any ack here is ignored, request re-issued.
          imem_req_d = 1'b1;
        end else if (imem_ack) begin
          instr_d       = imem_rdata;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b1;
          state_d       = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ex_done) begin
          instr_count_d = instr_count + 16'd1;
          pc_d          = next_pc_c;
          instr_valid_d = 1'b0;
          if (run) begin
            state_d     = S_REQ;
            imem_req_d  = 1'b1;
            imem_addr_d = next_pc_c;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
